// File: rtl/xbus_pkg.sv
// Shared constants and FSM state type for the xbus writer/reader arbiter.
package xbus_pkg;
    localparam int unsigned DW       = 11;
    localparam int unsigned N_WR_DEF = 4;
    localparam int unsigned N_RD_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);
    always_comb begin
        int unsigned cand;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid_c && req[IW'(cand)]) begin
                valid_c = 1'b1;
                idx_c   = IW'(cand);
            end
        end
    end
endmodule

// File: rtl/xbus_arbiter.sv
// Pairs one writer with one reader per transfer, round-robin on each side;
// each transfer occupies one XFER cycle with registered acks and data.
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int unsigned N_WR = N_WR_DEF,
    parameter int unsigned N_RD = N_RD_DEF,
    parameter int unsigned DW   = xbus_pkg::DW,
    localparam int unsigned WW  = (N_WR > 1) ? $clog2(N_WR) : 1,
    localparam int unsigned RW  = (N_RD > 1) ? $clog2(N_RD) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [N_WR-1:0]        wr_req,
    input  logic [N_WR*DW-1:0]     wr_data,
    output logic [N_WR-1:0]        wr_ack,
    input  logic [N_RD-1:0]        rd_req,
    output logic [N_RD-1:0]        rd_ack,
    output logic signed [DW-1:0]   rd_data,
    output logic                   busy,
    output logic [7:0]             xfer_cnt,
    output logic                   proto_err
);
    state_t                state, state_nxt;
    logic [WW-1:0]         wr_ptr, wr_ptr_nxt, w_sel, w_sel_nxt, w_idx;
    logic [RW-1:0]         rd_ptr, rd_ptr_nxt, r_sel, r_sel_nxt, r_idx;
    logic                  w_valid, r_valid;
    logic signed [DW-1:0]  xdata, xdata_nxt, rd_data_nxt;
    logic [N_WR-1:0]       wr_ack_nxt;
    logic [N_RD-1:0]       rd_ack_nxt;
    logic                  busy_nxt, proto_err_nxt;
    logic [7:0]            xfer_cnt_nxt;

    rr_pick #(.N(N_WR)) u_wr_pick (
        .req     (wr_req),
        .ptr     (wr_ptr),
        .idx_c   (w_idx),
        .valid_c (w_valid)
    );

    rr_pick #(.N(N_RD)) u_rd_pick (
        .req     (rd_req),
        .ptr     (rd_ptr),
        .idx_c   (r_idx),
        .valid_c (r_valid)
    );

    // Next-state and next-output logic; acks only exist for the single XFER cycle.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        w_sel_nxt     = w_sel;
        r_sel_nxt     = r_sel;
        xdata_nxt     = xdata;
        wr_ack_nxt    = '0;
        rd_ack_nxt    = '0;
        rd_data_nxt   = rd_data;
        busy_nxt      = 1'b0;
        xfer_cnt_nxt  = xfer_cnt;
        proto_err_nxt = proto_err;
        unique case (state)
            IDLE: begin
                if (w_valid && r_valid) begin
                    state_nxt             = XFER;
                    w_sel_nxt             = w_idx;
                    r_sel_nxt             = r_idx;
                    xdata_nxt             = wr_data[32'(w_idx)*DW +: DW];
                    wr_ack_nxt[w_idx]     = 1'b1;
                    rd_ack_nxt[r_idx]     = 1'b1;
                    rd_data_nxt           = xdata_nxt;
                    busy_nxt              = 1'b1;
                end
            end
            XFER: begin
                state_nxt    = IDLE;
                wr_ptr_nxt   = (32'(w_sel) == N_WR - 1) ? '0 : w_sel + WW'(1);
                rd_ptr_nxt   = (32'(r_sel) == N_RD - 1) ? '0 : r_sel + RW'(1);
                xfer_cnt_nxt = xfer_cnt + 8'd1;
                if (!wr_req[w_sel] || !rd_req[r_sel]) begin
                    proto_err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            w_sel     <= '0;
            r_sel     <= '0;
            xdata     <= '0;
            wr_ack    <= '0;
            rd_ack    <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            xfer_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            w_sel     <= w_sel_nxt;
            r_sel     <= r_sel_nxt;
            xdata     <= xdata_nxt;
            wr_ack    <= wr_ack_nxt;
            rd_ack    <= rd_ack_nxt;
            rd_data   <= rd_data_nxt;
            busy      <= busy_nxt;
            xfer_cnt  <= xfer_cnt_nxt;
            proto_err <= proto_err_nxt;
        end
    end
endmodule

// File: doc/xbus_arbiter.md
XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 Parameter N_WR, default 4: number of writer requesters.
REQ-002 Parameter N_RD, default 4: number of reader requesters.
REQ-003 Parameter DW, default 11: signed data width; covers -999..999.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 nrst  input  1  reset, synchronous, active-low.
REQ-006 wr_req  input  N_WR  per-writer transfer request; held high until acked.
REQ-007 wr_data  input  N_WR*DW  per-writer signed payload; slice i is bits [i*DW +: DW].
REQ-008 wr_ack  output  N_WR  one-hot, one-cycle pulse to the writer whose transfer completed.
REQ-009 rd_req  input  N_RD  per-reader transfer request; held high until acked.
REQ-010 rd_ack  output  N_RD  one-hot, one-cycle pulse to the reader receiving data.
REQ-011 rd_data  output  DW  value delivered; valid with rd_ack, then held.
REQ-012 busy  output  1  high while FSM is in XFER.
REQ-013 xfer_cnt  output  8  count of completed transfers; wraps 255 -> 0.
REQ-014 proto_err  output  1  sticky flag for a requester protocol violation.

Function
REQ-015 FSM states: IDLE and XFER only.
REQ-016 IDLE -> XFER when |wr_req and |rd_req are both high at a posedge.
- Same edge: latch winning writer index w, reader index r and wr_data slice w into xdata.
REQ-017 Writer choice is round-robin: lowest index >= wr_ptr with wr_req set, wrapping modulo N_WR; reader choice is identical using rd_ptr.
REQ-018 In XFER:
- wr_ack[w] = 1, rd_ack[r] = 1, rd_data = xdata, all other acks 0.
- Acks are registered outputs.
REQ-019 XFER -> IDLE unconditionally after one cycle.
- Same edge: wr_ptr <= (w+1) mod N_WR, rd_ptr <= (r+1) mod N_RD, xfer_cnt increments.
REQ-020 Latency: both requests high at edge t -> acks high in the cycle after t -> back in IDLE at t+2.
- Maximum throughput is one transfer per 2 cycles.
REQ-021 Requesters deassert req on the edge that samples their ack.
- The arbiter never re-grants in the cycle immediately following XFER from a stale request.
REQ-022 Only writers, or only readers, requesting: stay in IDLE indefinitely; pointers, acks and rd_data unchanged.
REQ-023 Latched grant completes even if wr_req[w] or rd_req[r] drops during XFER.
- If either is sampled low at the XFER edge, set proto_err; it stays set until reset.
REQ-024 rd_data holds its last delivered value outside XFER.
REQ-025 Payload passes unmodified; no saturation or sign change.
REQ-026 Simultaneous requests from several writers/readers: exactly one pair per transfer; the others wait, with no starvation beyond N-1 transfers on each side.

Reset
REQ-027 nrst low at a posedge forces:
- state = IDLE, wr_ptr = 0, rd_ptr = 0, xdata = 0;
- wr_ack = 0, rd_ack = 0, rd_data = 0, busy = 0, xfer_cnt = 0, proto_err = 0.
REQ-028 Reset asserted during XFER aborts the transfer: no pointer or count update, and acks are 0 from the next cycle.
REQ-029 Reset is sampled only on posedge clk; no asynchronous path.

Structure
REQ-030 Package xbus_pkg holds DW, the default N_WR/N_RD, and the state enum {IDLE, XFER}.
REQ-031 Sub-module rr_pick (request vector, pointer -> index, valid) is instantiated twice, once for writers and once for readers.
REQ-032 rr_pick is purely combinational; all registers live in xbus_arbiter.

Verification
REQ-033 Writer 2 requests with data -5 and reader 1 requests, both at edge 0:
- cycle 1: wr_ack = 0100, rd_ack = 0010, rd_data = -5, busy = 1;
- cycle 2: IDLE, xfer_cnt = 1.
REQ-034 All writers hold requests with data 10/20/30/40 and one reader re-requests after each ack:
- rd_data sequence is 10, 20, 30, 40, 10.
REQ-035 Writer 0 requests alone for 20 cycles, then reader 3 requests:
- no acks during the 20 cycles;
- single transfer follows with 1-cycle latency.
REQ-036 Writer drops wr_req during XFER:
- transfer still completes;
- proto_err = 1 and stays set until nrst.
REQ-037 nrst pulled low during XFER:
- next cycle all outputs are 0;
- following transfer picks writer 0 and reader 0.
REQ-038 Run 256 transfers: xfer_cnt wraps to 0; data value 999 and -999 delivered intact.
